// File: rtl/reg_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single register-file port.
// Define REG_BUS_ARBITER_FIXED_PRIO_EN to give m0 fixed priority instead.
module reg_bus_arbiter #(
    parameter int ADDR_W  = 2,
    parameter int DATA_W  = 32,
    parameter int RD_WAIT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              reg_wren,
    output logic [ADDR_W-1:0] reg_wraddr,
    output logic [DATA_W-1:0] reg_wrdata,
    output logic              reg_rden,
    output logic [ADDR_W-1:0] reg_rdaddr,
    input  logic [DATA_W-1:0] reg_rddata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ACK
    } state_t;

    localparam logic [3:0] RDW = 4'(RD_WAIT);

    state_t state_q, state_d;

    logic       grant_q, grant_d;
    logic       last_q, last_d;
    logic       we_q, we_d;
    logic [3:0] cnt_q, cnt_d;

    logic              wren_d, rden_d;
    logic              ack0_d, ack1_d;
    logic [ADDR_W-1:0] wraddr_d, rdaddr_d;
    logic [DATA_W-1:0] wrdata_d;
    logic [DATA_W-1:0] rdata0_d, rdata1_d;
    logic              busy_d;

    logic              pick;
    logic              both_pick;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              done;

`ifdef REG_BUS_ARBITER_FIXED_PRIO_EN
    assign both_pick = 1'b0;
`else
    assign both_pick = ~last_q;
`endif

    always_comb begin
        pick = 1'b0;
        unique case (1'b1)
            m0_req && m1_req:  pick = both_pick;
            m0_req && !m1_req: pick = 1'b0;
            default:           pick = 1'b1;
        endcase
    end

    assign sel_we    = pick ? m1_we    : m0_we;
    assign sel_addr  = pick ? m1_addr  : m0_addr;
    assign sel_wdata = pick ? m1_wdata : m0_wdata;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        we_d     = we_q;
        cnt_d    = cnt_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        wraddr_d = reg_wraddr;
        wrdata_d = reg_wrdata;
        rdaddr_d = reg_rdaddr;
        rdata0_d = m0_rdata;
        rdata1_d = m1_rdata;
        done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    grant_d = pick;
                    last_d  = pick;
                    we_d    = sel_we;
                    state_d = ISSUE;
                    if (sel_we) begin
                        wren_d   = 1'b1;
                        wraddr_d = sel_addr;
                        wrdata_d = sel_wdata;
                    end else begin
                        rden_d   = 1'b1;
                        rdaddr_d = sel_addr;
                    end
                end
            end
            ISSUE: begin
                if (we_q || RD_WAIT == 0) begin
                    done = 1'b1;
                end else begin
                    cnt_d   = RDW;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    done = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
        endcase

        // Read data is captured on the edge that enters ACK so it is
        // valid together with the ack pulse.
        if (done) begin
            state_d = ACK;
            ack0_d  = ~grant_q;
            ack1_d  = grant_q;
            if (!we_q) begin
                if (grant_q) begin
                    rdata1_d = reg_rddata;
                end else begin
                    rdata0_d = reg_rddata;
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_wren   <= 1'b0;
            reg_rden   <= 1'b0;
            reg_wraddr <= '0;
            reg_wrdata <= '0;
            reg_rdaddr <= '0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            busy       <= 1'b0;
        end else begin
            reg_wren   <= wren_d;
            reg_rden   <= rden_d;
            reg_wraddr <= wraddr_d;
            reg_wrdata <= wrdata_d;
            reg_rdaddr <= rdaddr_d;
            m0_ack     <= ack0_d;
            m1_ack     <= ack1_d;
            m0_rdata   <= rdata0_d;
            m1_rdata   <= rdata1_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter, plus a RD_WAIT=3 instance
// exercised directly for read-wait timing.
module tb_reg_bus_arbiter;

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m0_ack;
    logic [1:0]  m0_addr;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_we, m1_ack;
    logic [1:0]  m1_addr;
    logic [31:0] m1_wdata, m1_rdata;
    logic        reg_wren, reg_rden, busy;
    logic [1:0]  reg_wraddr, reg_rdaddr;
    logic [31:0] reg_wrdata, reg_rddata;

    logic        t3_req, t3_we, t3_ack;
    logic [1:0]  t3_addr;
    logic [31:0] t3_wdata, t3_rdata;
    logic        t3_m1_req, t3_m1_we, t3_m1_ack;
    logic [1:0]  t3_m1_addr;
    logic [31:0] t3_m1_wdata, t3_m1_rdata;
    logic        t3_wren, t3_rden, t3_busy;
    logic [1:0]  t3_wraddr, t3_rdaddr;
    logic [31:0] t3_wrdata, t3_rddata;

    typedef struct {
        bit          m;
        bit          we;
        logic [1:0]  addr;
        logic [31:0] data;
    } txn_t;

    txn_t        sb[$];
    logic [31:0] bank   [4];
    logic [31:0] shadow [4];
    logic [31:0] exp_rdata [2];
    int          cyc;
    int          n_checks;
    int          n_errors;
    int          strobe_cyc;
    int          ack_cyc;
    int          last_samp;
    bit          seen55;
    logic [15:0] cyc16;

    reg_bus_arbiter #(.ADDR_W(2), .DATA_W(32), .RD_WAIT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .reg_wren(reg_wren), .reg_wraddr(reg_wraddr),
        .reg_wrdata(reg_wrdata), .reg_rden(reg_rden),
        .reg_rdaddr(reg_rdaddr), .reg_rddata(reg_rddata),
        .busy(busy)
    );

    reg_bus_arbiter #(.ADDR_W(2), .DATA_W(32), .RD_WAIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(t3_req), .m0_we(t3_we), .m0_addr(t3_addr),
        .m0_wdata(t3_wdata), .m0_ack(t3_ack), .m0_rdata(t3_rdata),
        .m1_req(t3_m1_req), .m1_we(t3_m1_we), .m1_addr(t3_m1_addr),
        .m1_wdata(t3_m1_wdata), .m1_ack(t3_m1_ack),
        .m1_rdata(t3_m1_rdata),
        .reg_wren(t3_wren), .reg_wraddr(t3_wraddr),
        .reg_wrdata(t3_wrdata), .reg_rden(t3_rden),
        .reg_rdaddr(t3_rdaddr), .reg_rddata(t3_rddata),
        .busy(t3_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    assign cyc16      = cyc[15:0];
    assign reg_rddata = bank[reg_rdaddr];
    // Time-stamped read data shows which cycle the slow read captured.
    assign t3_rddata  = {14'h0, t3_rdaddr, cyc16};

    initial begin
        for (int i = 0; i < 4; i++) bank[i] = '0;
        forever begin
            @(posedge clk);
            if (reg_wren) bank[reg_wraddr] <= reg_wrdata;
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input bit m, input bit we, input logic [1:0] a,
                        input logic [31:0] d);
        txn_t t;
        t.m    = m;
        t.we   = we;
        t.addr = a;
        t.data = we ? d : shadow[a];
        if (we) shadow[a] = d;
        sb.push_back(t);
    endtask

    task automatic wait_ack(input bit m);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (m ? m1_ack : m0_ack) begin
                got = 1'b1;
                break;
            end
        end
        check(m ? "ack_timeout_m1" : "ack_timeout_m0", 64'(got), 64'(1));
    endtask

    task automatic drive(input bit m, input bit we, input logic [1:0] a,
                         input logic [31:0] d, input bit hold);
        if (!m) begin
            m0_req = 1'b1; m0_we = we; m0_addr = a; m0_wdata = d;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = a; m1_wdata = d;
        end
        last_samp = cyc + 1;
        wait_ack(m);
        @(posedge clk); #1;
        if (!hold) begin
            if (!m) m0_req = 1'b0;
            else    m1_req = 1'b0;
        end
    endtask

    task automatic check_idle(input string p);
        check({p, "_wren"},   64'(reg_wren),   64'(0));
        check({p, "_rden"},   64'(reg_rden),   64'(0));
        check({p, "_wraddr"}, 64'(reg_wraddr), 64'(0));
        check({p, "_wrdata"}, 64'(reg_wrdata), 64'(0));
        check({p, "_rdaddr"}, 64'(reg_rdaddr), 64'(0));
        check({p, "_ack0"},   64'(m0_ack),     64'(0));
        check({p, "_ack1"},   64'(m1_ack),     64'(0));
        check({p, "_rdata0"}, 64'(m0_rdata),   64'(0));
        check({p, "_rdata1"}, 64'(m1_rdata),   64'(0));
        check({p, "_busy"},   64'(busy),       64'(0));
    endtask

    initial begin
        bit   prev_s, prev_a;
        txn_t t;
        prev_s = 1'b0;
        prev_a = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_s = 1'b0;
                prev_a = 1'b0;
            end else begin
                if (reg_wrdata == 32'h55) seen55 = 1'b1;
                if (reg_wren | reg_rden) begin
                    check("strobe_excl", 64'(reg_wren & reg_rden), 64'(0));
                    check("strobe_width", 64'(prev_s), 64'(0));
                    check("busy", 64'(busy), 64'(1));
                    strobe_cyc = cyc + 1;
                    check("sb_strobe", 64'(sb.size() != 0), 64'(1));
                    if (sb.size() != 0) begin
                        t = sb[0];
                        check("strobe_we", 64'(reg_wren), 64'(t.we));
                        if (reg_wren) begin
                            check("wraddr", 64'(reg_wraddr), 64'(t.addr));
                            check("wrdata", 64'(reg_wrdata), 64'(t.data));
                        end else begin
                            check("rdaddr", 64'(reg_rdaddr), 64'(t.addr));
                        end
                    end
                end
                if (m0_ack | m1_ack) begin
                    check("ack_excl", 64'(m0_ack & m1_ack), 64'(0));
                    check("ack_width", 64'(prev_a), 64'(0));
                    ack_cyc = cyc + 1;
                    check("sb_ack", 64'(sb.size() != 0), 64'(1));
                    if (sb.size() != 0) begin
                        t = sb.pop_front();
                        check("ack_master", 64'(m1_ack), 64'(t.m));
                        if (!t.we) exp_rdata[t.m] = t.data;
                        check("rdata0", 64'(m0_rdata), 64'(exp_rdata[0]));
                        check("rdata1", 64'(m1_rdata), 64'(exp_rdata[1]));
                    end
                end
                prev_s = reg_wren | reg_rden;
                prev_a = m0_ack | m1_ack;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n, rd_cnt, rd_first, ack_c;
        bit          held, got;
        logic [31:0] cap, e;

        n_checks = 0; n_errors = 0; seen55 = 1'b0;
        strobe_cyc = -1; ack_cyc = -1; last_samp = 0;
        for (int i = 0; i < 4; i++) shadow[i] = '0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        t3_req = 0; t3_we = 0; t3_addr = 0; t3_wdata = 0;
        t3_m1_req = 0; t3_m1_we = 0; t3_m1_addr = 0; t3_m1_wdata = 0;

        repeat (2) @(negedge clk);
        check_idle("rst");
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("rel");
        @(posedge clk); #1;

        push(0, 1, 2, 32'hDEAD_BEEF);
        drive(0, 1, 2, 32'hDEAD_BEEF, 0);
        check("wr_strobe_lat", 64'(strobe_cyc), 64'(last_samp + 1));
        check("wr_ack_lat", 64'(ack_cyc), 64'(last_samp + 2));

        push(1, 0, 2, 0);
        drive(1, 0, 2, 0, 0);
        check("rd_strobe_lat", 64'(strobe_cyc), 64'(last_samp + 1));
        check("rd_ack_lat", 64'(ack_cyc), 64'(last_samp + 2));

`ifdef REG_BUS_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < 4; i++) push(0, 1, 2'(i), 32'(1 + 2 * i));
        for (int i = 0; i < 4; i++) push(1, 1, 2'(i), 32'(2 + 2 * i));
`else
        for (int i = 0; i < 4; i++) begin
            push(0, 1, 2'(i), 32'(1 + 2 * i));
            push(1, 1, 2'(i), 32'(2 + 2 * i));
        end
`endif
        fork
            begin
                for (int i = 0; i < 4; i++)
                    drive(0, 1, 2'(i), 32'(1 + 2 * i), i != 3);
            end
            begin
                for (int j = 0; j < 4; j++)
                    drive(1, 1, 2'(j), 32'(2 + 2 * j), j != 3);
            end
        join

        push(0, 0, 3, 0);
        drive(0, 0, 3, 0, 0);

        t3_req = 1'b1; t3_we = 1'b0; t3_addr = 2'd1;
        n = cyc + 1;
        rd_cnt = 0; rd_first = -1; ack_c = -1; held = 1'b1; cap = '0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (t3_rden) begin
                rd_cnt++;
                if (rd_first < 0) rd_first = cyc;
            end
            if (cyc >= n && cyc <= n + 3 && t3_rdaddr != 2'd1) held = 1'b0;
            if (t3_ack && ack_c < 0) begin
                ack_c  = cyc;
                cap    = t3_rdata;
                t3_req = 1'b0;
            end
        end
        e = {14'h0, 2'd1, 16'(n + 3)};
        check("w3_rden_count", 64'(rd_cnt), 64'(1));
        check("w3_rden_cyc", 64'(rd_first), 64'(n));
        check("w3_rdaddr_held", 64'(held), 64'(1));
        check("w3_ack_cyc", 64'(ack_c), 64'(n + 4));
        check("w3_rdata", 64'(cap), 64'(e));
        @(posedge clk); #1;

        push(0, 1, 1, 32'h1234_5678);
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 2'd1; m0_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        m0_addr = 2'd3; m0_wdata = 32'h55;
        wait_ack(0);
        @(posedge clk); #1 m0_req = 1'b0;
        push(0, 0, 1, 0);
        drive(0, 0, 1, 0, 0);
        push(0, 0, 3, 0);
        drive(0, 0, 3, 0, 0);

        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 2'd0; m0_wdata = 32'h77;
        @(posedge clk); #1;
        check("abort_in_issue", 64'(reg_wren), 64'(1));
        rst_n = 1'b0; m0_req = 1'b0;
        #1;
        check_idle("abort");
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        @(posedge clk); #1 rst_n = 1'b1;
        got = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (reg_wren | m0_ack) got = 1'b1;
        end
        check("abort_quiet", 64'(got), 64'(0));
        @(posedge clk); #1;

        push(0, 1, 0, 32'hA0);
        push(1, 1, 1, 32'hB1);
        fork
            drive(0, 1, 0, 32'hA0, 0);
            drive(1, 1, 1, 32'hB1, 0);
        join
        push(1, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("no_0x55_write", 64'(seen55), 64'(0));
        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
